// File: rtl/ram_bank_arbiter.sv
// rtl/ram_bank_arbiter.sv - Banked RAM with host/engine port arbitration and a command handshake FSM
//
// Purpose:
//   NBANK RAM banks, each 2^ADDR x DATA, with a dedicated engine port per bank
//   and one host port shared across all banks. The host address space also has
//   a control region (bank field 0) holding a command register (word 0) and a
//   status register (word 1). Host command writes drive a 3-state command FSM
//   (IDLE -> ISSUE -> BUSY) that hands the command to the engine.
//
// Optional feature:
//   RAM_BANK_WRITE_BYPASS_EN - when defined, an engine read of the address it
//   writes in the same cycle returns the new data; otherwise the old data.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   h_req, h_we, h_addr     host request, write flag, {bank, word} address
//   h_wdata, h_rdata        host write / read data
//   h_gnt                   host request accepted this cycle (combinational)
//   h_rvalid                h_rdata carries read data for the previous grant
//   e_we, e_addr, e_wdata   per-bank engine write enable, address, write data
//   e_rdata                 per-bank engine read data (1-cycle latency)
//   cmd, cmd_valid, cmd_ack command offered to the engine and its acceptance
//   eng_done                engine finished the current command (pulse)

module ram_bank_arbiter #(
    parameter int DATA  = 256,
    parameter int ADDR  = 3,
    parameter int NBANK = 4,
    localparam int BW    = $clog2(NBANK + 1),
    localparam int DEPTH = 1 << ADDR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  h_req,
    input  logic                  h_we,
    input  logic [BW+ADDR-1:0]    h_addr,
    input  logic [DATA-1:0]       h_wdata,
    output logic [DATA-1:0]       h_rdata,
    output logic                  h_gnt,
    output logic                  h_rvalid,
    input  logic [NBANK-1:0]      e_we,
    input  logic [NBANK*ADDR-1:0] e_addr,
    input  logic [NBANK*DATA-1:0] e_wdata,
    output logic [NBANK*DATA-1:0] e_rdata,
    output logic [3:0]            cmd,
    output logic                  cmd_valid,
    input  logic                  cmd_ack,
    input  logic                  eng_done
);

`ifdef RAM_BANK_WRITE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    state_t state;
    logic   err;

    logic [BW-1:0]         h_bank;
    logic [ADDR-1:0]       h_word;
    logic                  eng_block;
    logic [NBANK*DATA-1:0] bank_rd;
    logic [DATA-1:0]       rd_next;
    logic [2:0]            status;
    logic                  ctl_wr;
    logic                  cmd_wr;
    logic                  clr_wr;
    logic                  host_rd;

    assign h_bank = h_addr[BW+ADDR-1:ADDR];
    assign h_word = h_addr[ADDR-1:0];

    // The engine owns a bank for the cycle it writes it; the host is simply
    // held off so neither write is lost or merged. Control space and
    // out-of-range banks never collide with an engine.
    always_comb begin
        eng_block = 1'b0;
        for (int k = 0; k < NBANK; k++) begin
            if (h_bank == BW'(k + 1) && e_we[k]) begin
                eng_block = 1'b1;
            end
        end
    end

    assign h_gnt   = h_req && !eng_block;
    assign host_rd = h_gnt && !h_we;
    assign ctl_wr  = h_gnt && h_we && (h_bank == '0);
    assign cmd_wr  = ctl_wr && (h_word == ADDR'(0));
    assign clr_wr  = ctl_wr && (h_word == ADDR'(1));

    assign status = {err, state == S_BUSY, state == S_ISSUE};

    for (genvar k = 0; k < NBANK; k++) begin : g_bank
        logic [DATA-1:0] mem [DEPTH];
        logic [ADDR-1:0] ea;
        logic [DATA-1:0] ewd;
        logic            host_wr;

        assign ea      = e_addr[k*ADDR +: ADDR];
        assign ewd     = e_wdata[k*DATA +: DATA];
        assign host_wr = h_gnt && h_we && (h_bank == BW'(k + 1));

        // Grant logic guarantees the engine and host never write the same
        // bank in one cycle, so the priority here is only for clarity.
        always_ff @(posedge clk) begin
            if (e_we[k]) begin
                mem[ea] <= ewd;
            end else if (host_wr) begin
                mem[h_word] <= h_wdata;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                e_rdata[k*DATA +: DATA] <= '0;
            end else if (BYPASS && e_we[k]) begin
                e_rdata[k*DATA +: DATA] <= ewd;
            end else begin
                e_rdata[k*DATA +: DATA] <= mem[ea];
            end
        end

        // Host view of this bank, sampled into h_rdata before any write of
        // the same edge lands (read-before-write).
        assign bank_rd[k*DATA +: DATA] = mem[h_word];
    end

    always_comb begin
        rd_next = '0;
        if (h_bank == '0) begin
            if (h_word == ADDR'(1)) begin
                rd_next = DATA'(status);
            end
        end else begin
            for (int k = 0; k < NBANK; k++) begin
                if (h_bank == BW'(k + 1)) begin
                    rd_next = bank_rd[k*DATA +: DATA];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_rvalid <= 1'b0;
            h_rdata  <= '0;
        end else begin
            h_rvalid <= host_rd;
            if (host_rd) begin
                h_rdata <= rd_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cmd       <= 4'd0;
            cmd_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (clr_wr) begin
                err <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (cmd_wr) begin
                        cmd       <= h_wdata[3:0];
                        cmd_valid <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (cmd_wr) begin
                        err <= 1'b1;
                    end
                    if (cmd_ack) begin
                        cmd_valid <= 1'b0;
                        state     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (cmd_wr) begin
                        err <= 1'b1;
                    end
                    if (eng_done) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    cmd_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bank_arbiter.sv
// tb/tb_ram_bank_arbiter.sv - Self-checking bench for ram_bank_arbiter against a behavioural model
module tb_ram_bank_arbiter;

    localparam int DATA  = 256;
    localparam int ADDR  = 3;
    localparam int NBANK = 4;
    localparam int BW    = 3;
    localparam int DEPTH = 8;

`ifdef RAM_BANK_WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  h_req;
    logic                  h_we;
    logic [BW+ADDR-1:0]    h_addr;
    logic [DATA-1:0]       h_wdata;
    logic [DATA-1:0]       h_rdata;
    logic                  h_gnt;
    logic                  h_rvalid;
    logic [NBANK-1:0]      e_we;
    logic [NBANK*ADDR-1:0] e_addr;
    logic [NBANK*DATA-1:0] e_wdata;
    logic [NBANK*DATA-1:0] e_rdata;
    logic [3:0]            cmd;
    logic                  cmd_valid;
    logic                  cmd_ack;
    logic                  eng_done;

    ram_bank_arbiter #(.DATA(DATA), .ADDR(ADDR), .NBANK(NBANK)) dut (
        .clk(clk), .rst_n(rst_n),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_rdata(h_rdata), .h_gnt(h_gnt), .h_rvalid(h_rvalid),
        .e_we(e_we), .e_addr(e_addr), .e_wdata(e_wdata), .e_rdata(e_rdata),
        .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ack(cmd_ack), .eng_done(eng_done)
    );

    always #5 clk = ~clk;

    // Behavioural model: memory contents with known-flags, command
    // bookkeeping as plain flags, and expected registered outputs.
    logic [DATA-1:0] m_mem [NBANK][DEPTH];
    bit              m_ok  [NBANK][DEPTH];
    logic [DATA-1:0] m_erd [NBANK];
    bit              m_erd_ok [NBANK];
    logic [DATA-1:0] m_hrd;
    bit              m_hrd_ok;
    bit              m_rvalid;
    bit              m_pending, m_busy, m_err;
    logic [3:0]      m_cmd;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [DATA-1:0] got, input logic [DATA-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA-1:0] rand_word();
        logic [DATA-1:0] v;
        for (int i = 0; i < DATA / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_reset();
        m_pending = 0; m_busy = 0; m_err = 0; m_cmd = 4'd0;
        m_hrd = '0; m_hrd_ok = 1; m_rvalid = 0;
        for (int k = 0; k < NBANK; k++) begin
            m_erd[k] = '0;
            m_erd_ok[k] = 1;
        end
    endtask

    task automatic set_idle();
        h_req = 0; h_we = 0; h_addr = '0; h_wdata = '0;
        e_we = '0; e_addr = '0; e_wdata = '0;
        cmd_ack = 0; eng_done = 0;
    endtask

    task automatic host(input bit we, input int bank, input int word, input logic [DATA-1:0] d);
        h_req = 1; h_we = we;
        h_addr = {BW'(bank), ADDR'(word)};
        h_wdata = d;
    endtask

    // Called about 1 time unit after a rising edge with inputs already driven.
    task automatic cycle();
        int bank, word;
        bit gnt_e;
        bank = int'(h_addr[BW+ADDR-1:ADDR]);
        word = int'(h_addr[ADDR-1:0]);
        #1;
        gnt_e = h_req;
        if (bank >= 1 && bank <= NBANK) begin
            if (e_we[bank-1]) gnt_e = 0;
        end
        check("h_gnt", DATA'(h_gnt), DATA'(gnt_e));

        for (int k = 0; k < NBANK; k++) begin
            int ea;
            ea = int'(e_addr[k*ADDR +: ADDR]);
            if (BYP && e_we[k]) begin
                m_erd[k] = e_wdata[k*DATA +: DATA];
                m_erd_ok[k] = 1;
            end else begin
                m_erd[k] = m_mem[k][ea];
                m_erd_ok[k] = m_ok[k][ea];
            end
        end

        m_rvalid = gnt_e && !h_we;
        if (m_rvalid) begin
            m_hrd_ok = 1;
            if (bank == 0) m_hrd = (word == 1) ? DATA'({m_err, m_busy, m_pending}) : '0;
            else if (bank <= NBANK) begin
                m_hrd = m_mem[bank-1][word];
                m_hrd_ok = m_ok[bank-1][word];
            end else m_hrd = '0;
        end

        for (int k = 0; k < NBANK; k++) begin
            if (e_we[k]) begin
                m_mem[k][int'(e_addr[k*ADDR +: ADDR])] = e_wdata[k*DATA +: DATA];
                m_ok[k][int'(e_addr[k*ADDR +: ADDR])] = 1;
            end
        end
        if (gnt_e && h_we && bank >= 1 && bank <= NBANK) begin
            m_mem[bank-1][word] = h_wdata;
            m_ok[bank-1][word] = 1;
        end

        begin
            bit pre_p, pre_b;
            pre_p = m_pending; pre_b = m_busy;
            if (gnt_e && h_we && bank == 0) begin
                if (word == 0) begin
                    if (!pre_p && !pre_b) begin
                        m_cmd = h_wdata[3:0];
                        m_pending = 1;
                    end else m_err = 1;
                end
                if (word == 1) m_err = 0;
            end
            if (pre_p && cmd_ack) begin
                m_pending = 0;
                m_busy = 1;
            end
            if (pre_b && eng_done) m_busy = 0;
        end

        @(posedge clk);
        #1;
        check("h_rvalid", DATA'(h_rvalid), DATA'(m_rvalid));
        if (m_hrd_ok) check("h_rdata", h_rdata, m_hrd);
        for (int k = 0; k < NBANK; k++) begin
            if (m_erd_ok[k]) check($sformatf("e_rdata%0d", k), e_rdata[k*DATA +: DATA], m_erd[k]);
        end
        check("cmd", DATA'(cmd), DATA'(m_cmd));
        check("cmd_valid", DATA'(cmd_valid), DATA'(m_pending));
    endtask

    initial begin
        logic [DATA-1:0] old;
        set_idle();
        rst_n = 0;
        for (int k = 0; k < NBANK; k++)
            for (int w = 0; w < DEPTH; w++) m_ok[k][w] = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_h_rvalid", DATA'(h_rvalid), '0);
        check("rst_h_rdata", h_rdata, '0);
        check("rst_e_rdata", e_rdata[DATA-1:0], '0);
        check("rst_cmd", DATA'(cmd), '0);
        check("rst_cmd_valid", DATA'(cmd_valid), '0);
        rst_n = 1;

        // Fill every bank through the engine ports.
        for (int w = 0; w < DEPTH; w++) begin
            set_idle();
            e_we = '1;
            for (int k = 0; k < NBANK; k++) begin
                e_addr[k*ADDR +: ADDR] = ADDR'(w);
                e_wdata[k*DATA +: DATA] = rand_word();
            end
            cycle();
        end

        // Host write then read of bank 1 word 2.
        set_idle(); host(1, 1, 2, DATA'(8'hA5)); cycle();
        set_idle(); host(0, 1, 2, '0); cycle();
        check("rd_a5", h_rdata, DATA'(8'hA5));

        // Engine and host collide on bank 2 word 5.
        set_idle();
        e_we = 4'b0010; e_addr[1*ADDR +: ADDR] = 3'd5; e_wdata[1*DATA +: DATA] = DATA'(8'h11);
        host(1, 2, 5, DATA'(8'h22)); cycle();
        set_idle(); host(1, 2, 5, DATA'(8'h22)); cycle();
        set_idle(); host(0, 2, 5, '0); cycle();
        check("collide_final", h_rdata, DATA'(8'h22));

        // Command flow with a rejected command while busy.
        set_idle(); host(1, 0, 0, DATA'(7)); cycle();
        check("cmd7", DATA'(cmd), DATA'(7));
        set_idle(); eng_done = 1; cycle();
        set_idle(); cycle();
        set_idle(); cmd_ack = 1; cycle();
        set_idle(); host(0, 0, 1, '0); cycle();
        check("status_busy", h_rdata, DATA'(3'b010));
        set_idle(); host(1, 0, 0, DATA'(3)); cycle();
        set_idle(); host(0, 0, 1, '0); cycle();
        check("status_err", h_rdata, DATA'(3'b110));
        check("cmd_kept", DATA'(cmd), DATA'(7));
        set_idle(); eng_done = 1; cycle();
        set_idle(); host(1, 0, 1, '0); cycle();
        set_idle(); host(0, 0, 1, '0); cycle();
        check("status_clr", h_rdata, '0);

        // Out-of-range bank: granted, write ignored, reads zero.
        set_idle(); host(1, 6, 3, rand_word()); cycle();
        set_idle(); host(0, 6, 3, '0); cycle();
        check("oob_rd", h_rdata, '0);

        // Engine write with read of the same address.
        set_idle();
        old = m_mem[0][4];
        e_we = 4'b0001; e_addr[0 +: ADDR] = 3'd4; e_wdata[0 +: DATA] = DATA'(8'hFF);
        cycle();
        check("eng_bypass", e_rdata[0 +: DATA], BYP ? DATA'(8'hFF) : old);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            set_idle();
            h_req = 1'($urandom_range(0, 1));
            h_we = 1'($urandom_range(0, 1));
            h_addr = BW+ADDR'($urandom);
            h_wdata = rand_word();
            for (int k = 0; k < NBANK; k++) begin
                e_we[k] = ($urandom_range(0, 3) == 0);
                e_addr[k*ADDR +: ADDR] = ADDR'($urandom);
                e_wdata[k*DATA +: DATA] = rand_word();
            end
            cmd_ack = ($urandom_range(0, 9) < 3);
            eng_done = ($urandom_range(0, 9) < 2);
            cycle();
        end

        // Reset while a command is being offered.
        set_idle(); cmd_ack = 0; eng_done = 0;
        if (m_pending || m_busy) begin
            eng_done = m_busy;
            cycle();
            set_idle();
        end
        host(1, 0, 0, DATA'(5)); cycle();
        check("issue_valid", DATA'(cmd_valid), DATA'(1));
        set_idle();
        rst_n = 0;
        #1;
        check("rst_mid_cmd_valid", DATA'(cmd_valid), '0);
        check("rst_mid_cmd", DATA'(cmd), '0);
        check("rst_mid_rvalid", DATA'(h_rvalid), '0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        set_idle(); cmd_ack = 1; cycle();
        set_idle(); cycle();
        set_idle(); host(0, 0, 1, '0); cycle();
        check("post_rst_status", h_rdata, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
